conv_sched: RTL and testbench
=============================

// Module: conv_sched
// PURPOSE
//  Frame scheduler for the shared 2-tap signed convolution datapath y[n]=c0*x[n]+c1*x[n-1].
//  Accepts a sample stream (valid/ready), keeps the sliding window and coefficient registers, and issues one start/done job per output.
//  Saturates each result to RW bits and emits the full linear convolution: FRAME_LEN+1 outputs per frame.
// PARAMETERS
//  DW        12  sample width, signed
//  CW        12  coefficient width, signed
//  RW        13  output width, signed (saturated)
//  FRAME_LEN 8   samples per frame, >=1
//  C0_RST    2   c0 value after reset
//  C1_RST    -5  c1 value after reset
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-low; clears every register
//  cfg_we     in   1        coefficient write strobe
//  cfg_sel    in   1        0: c0, 1: c1
//  cfg_data   in   CW       coefficient value
//  in_valid   in   1        sample valid
//  in_data    in   DW       sample
//  in_ready   out  1        sample accepted when in_valid&&in_ready
//  dp_x0      out  DW       current sample to datapath
//  dp_x1      out  DW       previous sample to datapath
//  dp_c0      out  CW       active c0
//  dp_c1      out  CW       active c1
//  dp_start   out  1        one-cycle job pulse
//  dp_done    in   1        one-cycle job-complete pulse
//  dp_result  in   DW+CW+1  raw sum, valid with dp_done
//  out_valid  out  1        result valid
//  out_data   out  RW       saturated result
//  out_sat    out  1        out_data was clipped
//  out_last   out  1        last output of frame (tail)
//  out_ready  in   1        result consumed when out_valid&&out_ready
//  busy       out  1        frame in progress (state!=IDLE or cnt!=0)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cnt=0, x_prev=0, shadow c0/c1 = C0_RST/C1_RST; a frame in progress is aborted.
//  FSM: IDLE(in_ready=1) -> ISSUE -> WAIT -> OUT -> {FETCH(in_ready=1) | ISSUE(tail) | IDLE}.
//   IDLE: on accept, active c0/c1 <- shadow, x_cur<=in_data, x_prev=0, cnt=1, go ISSUE.
//   ISSUE: dp_start=1 for one cycle, dp_x0=x_cur, dp_x1=x_prev; go WAIT.
//   WAIT: hold dp_x*/dp_c* stable; on dp_done capture saturated dp_result, go OUT.
//   OUT: out_valid=1, data/sat/last held until out_ready; on handshake:
//    tail done -> IDLE, cnt=0, x_prev=0;
//    cnt==FRAME_LEN, tail not yet issued -> x_prev<=x_cur, x_cur<=0, go ISSUE with tail flag;
//    else -> x_prev<=x_cur, go FETCH.
//   FETCH: on accept, x_cur<=in_data, cnt++, go ISSUE.
//  in_ready is 1 only in IDLE and FETCH; never combinationally dependent on out_ready.
//  Min cost per output: 4 cycles (accept, ISSUE, dp_done the cycle after dp_start, out_ready high).
//  dp_done outside WAIT is ignored. dp_done in the same cycle as dp_start is not possible (start is issued from ISSUE).
//  Saturation: result > 2^(RW-1)-1 -> 2^(RW-1)-1; result < -2^(RW-1) -> -2^(RW-1); out_sat=1 in either case.
//  Config: cfg_we writes the shadow register every cycle, in any state. Active coefficients load only at frame start.
//   A write in the same cycle as the first-sample accept is NOT seen by that frame.
//  out_last=1 only on the tail output (index FRAME_LEN).
// STRUCTURE
//  conv_pkg: DW/CW/RW defaults, state enum (IDLE, ISSUE, WAIT, OUT, FETCH), function sat_rw().
//  Sub-module conv_sat: combinational DW+CW+1 -> RW clip plus sat flag; instantiated once in the WAIT capture path.
//  Remaining logic (FSM, cnt, window, coefficient regs) lives in conv_sched.
// TESTING (bench: FRAME_LEN=4, datapath model returns dp_done 1..3 cycles after dp_start)
//  Basic: c0=2, c1=-5, x=1,2,3,4 -> out 2,-1,-4,-7,-20; out_last only on -20; out_sat=0; busy falls after tail.
//  Saturation: c0=2047, c1=0, x=2047 -> 4095, sat=1; x=-2048 -> -4096, sat=1; x=1 -> 2047, sat=0.
//  Backpressure: out_ready low 5 cycles in OUT -> out_data/out_last stable, in_ready=0, no dp_start.
//  Config timing: write c0=1 mid-frame -> current frame still uses c0=2; next frame x=3 -> first out 3.
//  Reset mid-frame: reset low during WAIT after 2 outputs -> all outputs 0 asynchronously, coefficients = 2/-5.
//   Next frame x=1,1,1,1 -> 2,-3,-3,-3,-5.
//  Spurious dp_done in IDLE/FETCH/OUT -> no state change, no out_valid.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared widths, FSM state encoding and the result clip helper for the
// 2-tap convolution scheduler.
package conv_pkg;

    localparam int DW    = 12;
    localparam int CW    = 12;
    localparam int RW    = 13;
    localparam int RES_W = DW + CW + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        FETCH = 3'd4
    } state_t;

    typedef struct packed {
        logic [RW-1:0] data;
        logic          sat;
    } sat_t;

    // In range exactly when every bit from the RW sign position upward agrees.
    function automatic sat_t sat_rw(input logic signed [RES_W-1:0] v);
        sat_t                 r;
        logic [RES_W-RW:0]    top;
        top = v[RES_W-1:RW-1];
        if ((&top) || !(|top)) begin
            r.data = v[RW-1:0];
            r.sat  = 1'b0;
        end else if (v[RES_W-1]) begin
            r.data = {1'b1, {(RW-1){1'b0}}};
            r.sat  = 1'b1;
        end else begin
            r.data = {1'b0, {(RW-1){1'b1}}};
            r.sat  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_sat.sv
// Combinational clip of the raw datapath sum to RW bits, with a flag when
// the value had to be limited.
module conv_sat
    import conv_pkg::*;
(
    input  logic signed [RES_W-1:0] raw,
    output logic signed [RW-1:0]    data,
    output logic                    sat
);

    sat_t res_s;

    assign res_s = sat_rw(raw);
    assign data  = res_s.data;
    assign sat   = res_s.sat;

endmodule

// File: rtl/conv_sched.sv
// Frame scheduler for the shared 2-tap convolution datapath: sliding window,
// coefficient shadow/active registers and one start/done job per output.
module conv_sched
    import conv_pkg::*;
#(
    parameter int                    FRAME_LEN = 8,
    parameter logic signed [CW-1:0]  C0_RST    = 12'sd2,
    parameter logic signed [CW-1:0]  C1_RST    = -12'sd5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic                    cfg_sel,
    input  logic signed [CW-1:0]    cfg_data,
    input  logic                    in_valid,
    input  logic signed [DW-1:0]    in_data,
    output logic                    in_ready,
    output logic signed [DW-1:0]    dp_x0,
    output logic signed [DW-1:0]    dp_x1,
    output logic signed [CW-1:0]    dp_c0,
    output logic signed [CW-1:0]    dp_c1,
    output logic                    dp_start,
    input  logic                    dp_done,
    input  logic signed [RES_W-1:0] dp_result,
    output logic                    out_valid,
    output logic signed [RW-1:0]    out_data,
    output logic                    out_sat,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 tail_r;
    logic signed [DW-1:0] x_cur_r;
    logic signed [DW-1:0] x_prev_r;
    logic signed [CW-1:0] c0_sh_r;
    logic signed [CW-1:0] c1_sh_r;
    logic signed [CW-1:0] c0_act_r;
    logic signed [CW-1:0] c1_act_r;
    logic                 in_ready_r;
    logic                 dp_start_r;
    logic                 out_valid_r;
    logic signed [RW-1:0] out_data_r;
    logic                 out_sat_r;
    logic                 out_last_r;
    logic                 busy_r;
    logic signed [RW-1:0] sat_data_s;
    logic                 sat_flag_s;

    conv_sat u_sat (
        .raw  (dp_result),
        .data (sat_data_s),
        .sat  (sat_flag_s)
    );

    // Shadow coefficients accept writes at any time; frames copy them on start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c0_sh_r <= C0_RST;
            c1_sh_r <= C1_RST;
        end else if (cfg_we) begin
            if (cfg_sel) begin
                c1_sh_r <= cfg_data;
            end else begin
                c0_sh_r <= cfg_data;
            end
        end
    end

    // Job sequencing: accept sample, issue job, capture result, hand it off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            tail_r      <= 1'b0;
            x_cur_r     <= {DW{1'b0}};
            x_prev_r    <= {DW{1'b0}};
            c0_act_r    <= {CW{1'b0}};
            c1_act_r    <= {CW{1'b0}};
            in_ready_r  <= 1'b0;
            dp_start_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {RW{1'b0}};
            out_sat_r   <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        c0_act_r   <= c0_sh_r;
                        c1_act_r   <= c1_sh_r;
                        x_cur_r    <= in_data;
                        x_prev_r   <= {DW{1'b0}};
                        cnt_r      <= CNT_W'(1);
                        tail_r     <= 1'b0;
                        in_ready_r <= 1'b0;
                        dp_start_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ISSUE;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ISSUE: begin
                    dp_start_r <= 1'b0;
                    state_r    <= WAIT;
                end
                WAIT: begin
                    if (dp_done) begin
                        out_data_r  <= sat_data_s;
                        out_sat_r   <= sat_flag_s;
                        out_last_r  <= tail_r;
                        out_valid_r <= 1'b1;
                        state_r     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (tail_r) begin
                            cnt_r      <= {CNT_W{1'b0}};
                            x_prev_r   <= {DW{1'b0}};
                            tail_r     <= 1'b0;
                            out_last_r <= 1'b0;
                            busy_r     <= 1'b0;
                            in_ready_r <= 1'b1;
                            state_r    <= IDLE;
                        end else if (cnt_r == CNT_W'(FRAME_LEN)) begin
                            // Tail output flushes the last sample with a zero input.
                            x_prev_r   <= x_cur_r;
                            x_cur_r    <= {DW{1'b0}};
                            tail_r     <= 1'b1;
                            dp_start_r <= 1'b1;
                            state_r    <= ISSUE;
                        end else begin
                            x_prev_r   <= x_cur_r;
                            in_ready_r <= 1'b1;
                            state_r    <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (in_valid && in_ready_r) begin
                        x_cur_r    <= in_data;
                        cnt_r      <= cnt_r + CNT_W'(1);
                        in_ready_r <= 1'b0;
                        dp_start_r <= 1'b1;
                        state_r    <= ISSUE;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b0;
                    dp_start_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign dp_x0     = x_cur_r;
    assign dp_x1     = x_prev_r;
    assign dp_c0     = c0_act_r;
    assign dp_c1     = c1_act_r;
    assign dp_start  = dp_start_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_conv_sched.sv
// Randomized self-checking bench for conv_sched with a behavioural datapath
// responder and an arithmetic reference model of the linear convolution.
module tb_conv_sched;
    import conv_pkg::*;

    localparam int L = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    cfg_we = 1'b0;
    logic                    cfg_sel = 1'b0;
    logic signed [CW-1:0]    cfg_data = '0;
    logic                    in_valid = 1'b0;
    logic signed [DW-1:0]    in_data = '0;
    logic                    in_ready;
    logic signed [DW-1:0]    dp_x0, dp_x1;
    logic signed [CW-1:0]    dp_c0, dp_c1;
    logic                    dp_start;
    logic                    dp_done = 1'b0;
    logic signed [RES_W-1:0] dp_result = '0;
    logic                    out_valid;
    logic signed [RW-1:0]    out_data;
    logic                    out_sat, out_last;
    logic                    out_ready = 1'b0;
    logic                    busy;

    conv_sched #(.FRAME_LEN(L)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .dp_x0(dp_x0), .dp_x1(dp_x1), .dp_c0(dp_c0), .dp_c1(dp_c1),
        .dp_start(dp_start), .dp_done(dp_done), .dp_result(dp_result),
        .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat), .out_last(out_last),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int sh_c0    = 2;
    int sh_c1    = -5;
    bit spur_en  = 1'b0;
    int dp_pend  = 0;

    // Frame options
    int opt_stall, opt_mid_at, opt_mid_val, opt_first_cfg, opt_first_val, opt_abort_at;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int ref_sat(input int v);
        if (v > 4095) return 4095;
        if (v < -4096) return -4096;
        return v;
    endfunction

    function automatic int rand_s();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    // Behavioural datapath: answers each start 1..3 cycles later, optional stray dones.
    always @(negedge clk) begin
        int r;
        dp_done = 1'b0;
        if (!reset) begin
            dp_pend = 0;
        end else if (dp_start) begin
            r = int'(dp_x0) * int'(dp_c0) + int'(dp_x1) * int'(dp_c1);
            dp_result = RES_W'(r);
            dp_pend = int'($urandom_range(1, 3));
        end else if (dp_pend > 0) begin
            dp_pend--;
            if (dp_pend == 0) dp_done = 1'b1;
        end else if (spur_en && $urandom_range(0, 3) == 0) begin
            dp_done = 1'b1;
        end
    end

    task automatic set_defaults();
        opt_stall = -1; opt_mid_at = -1; opt_mid_val = 0;
        opt_first_cfg = 0; opt_first_val = 0; opt_abort_at = -1;
    endtask

    task automatic cfg_write(input bit sel, input int val);
        cfg_we = 1'b1; cfg_sel = sel; cfg_data = CW'(val);
        @(negedge clk);
        cfg_we = 1'b0;
        if (sel) sh_c1 = val; else sh_c0 = val;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_in_ready"}, in_ready, 0);
        check_eq({pfx, "_out_valid"}, out_valid, 0);
        check_eq({pfx, "_out_data"}, out_data, 0);
        check_eq({pfx, "_out_sat"}, out_sat, 0);
        check_eq({pfx, "_out_last"}, out_last, 0);
        check_eq({pfx, "_dp_start"}, dp_start, 0);
        check_eq({pfx, "_dp_x0"}, dp_x0, 0);
        check_eq({pfx, "_dp_x1"}, dp_x1, 0);
        check_eq({pfx, "_dp_c0"}, dp_c0, 0);
        check_eq({pfx, "_dp_c1"}, dp_c1, 0);
        check_eq({pfx, "_busy"}, busy, 0);
    endtask

    task automatic run_frame(input int xs[L], input int c0, input int c1);
        int n, raw, ev, es, xi, xp, st;
        for (int i = 0; i <= L; i++) begin
            if (i < L) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                n = 0;
                while (!in_ready && n < 40) begin @(negedge clk); n++; end
                if (!in_ready) check_eq("in_ready_timeout", 0, 1);
                in_valid = 1'b1; in_data = DW'(xs[i]);
                if (i == 0 && opt_first_cfg != 0) begin
                    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = CW'(opt_first_val);
                    sh_c0 = opt_first_val;
                end
                @(negedge clk);
                in_valid = 1'b0; cfg_we = 1'b0;
                if (i == 0) begin
                    check_eq("busy_start", busy, 1);
                    check_eq("dp_c0_active", dp_c0, c0);
                    check_eq("dp_c1_active", dp_c1, c1);
                end
                if (i == opt_abort_at) begin
                    check_eq("dp_start_issue", dp_start, 1);
                    @(negedge clk);
                    reset = 1'b0;
                    #1;
                    check_reset_outputs("midreset");
                    sh_c0 = 2; sh_c1 = -5;
                    return;
                end
            end
            n = 0;
            while (!out_valid && n < 40) begin @(negedge clk); n++; end
            if (!out_valid) check_eq("out_valid_timeout", 0, 1);
            xi  = (i < L) ? xs[i] : 0;
            xp  = (i > 0) ? xs[i-1] : 0;
            raw = c0 * xi + c1 * xp;
            ev  = ref_sat(raw);
            es  = (raw != ev) ? 1 : 0;
            check_eq($sformatf("out_data[%0d]", i), out_data, ev);
            check_eq($sformatf("out_sat[%0d]", i), out_sat, es);
            check_eq($sformatf("out_last[%0d]", i), out_last, (i == L) ? 1 : 0);
            if (i == opt_mid_at) cfg_write(1'b0, opt_mid_val);
            st = (opt_stall >= 0) ? opt_stall : int'($urandom_range(0, 2));
            repeat (st) begin
                @(negedge clk);
                check_eq("hold_out_data", out_data, ev);
                check_eq("hold_out_last", out_last, (i == L) ? 1 : 0);
                check_eq("hold_out_valid", out_valid, 1);
                check_eq("hold_in_ready", in_ready, 0);
                check_eq("hold_dp_start", dp_start, 0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check_eq("busy_end", busy, 0);
        check_eq("valid_after_tail", out_valid, 0);
    endtask

    initial begin
        int xs[L];
        int c0, c1;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        check_eq("idle_in_ready", in_ready, 1);

        // Basic frame with reset coefficients
        set_defaults();
        run_frame('{1, 2, 3, 4}, 2, -5);

        // Saturation in both directions and an in-range neighbour
        cfg_write(1'b0, 2047);
        cfg_write(1'b1, 0);
        run_frame('{2047, -2048, 1, 0}, 2047, 0);

        // Backpressure hold
        cfg_write(1'b0, 2);
        cfg_write(1'b1, -5);
        opt_stall = 5;
        run_frame('{rand_s(), rand_s(), rand_s(), rand_s()}, 2, -5);

        // Mid-frame config write is not seen until the next frame
        set_defaults();
        opt_mid_at = 1; opt_mid_val = 1;
        run_frame('{1, 2, 3, 4}, 2, -5);
        set_defaults();
        opt_first_cfg = 1; opt_first_val = 7;
        run_frame('{3, 0, 0, 0}, 1, -5);
        set_defaults();
        run_frame('{5, -1, 2, 0}, 7, -5);

        // Stray dp_done pulses must not disturb anything
        spur_en = 1'b1;
        run_frame('{rand_s(), rand_s(), rand_s(), rand_s()}, 7, -5);
        repeat (8) begin
            @(negedge clk);
            check_eq("spur_idle_valid", out_valid, 0);
            check_eq("spur_idle_busy", busy, 0);
        end
        spur_en = 1'b0;

        // Reset while waiting on the third job restores the reset coefficients
        cfg_write(1'b0, 9);
        set_defaults();
        opt_abort_at = 2;
        run_frame('{1, 2, 3, 4}, 9, -5);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        set_defaults();
        run_frame('{1, 1, 1, 1}, 2, -5);

        // Random frames with random coefficients
        for (int f = 0; f < 10; f++) begin
            set_defaults();
            spur_en = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) cfg_write(1'b0, rand_s());
            if ($urandom_range(0, 1) == 1) cfg_write(1'b1, rand_s());
            c0 = sh_c0; c1 = sh_c1;
            for (int k = 0; k < L; k++) xs[k] = rand_s();
            run_frame(xs, c0, c1);
        end
        spur_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
